// File: rtl/node_edge_sequencer_if.sv
// Parser-facing token port and graph-facing edge port of the node edge sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface node_edge_sequencer_if #(
    parameter int DEPTH = 1024,
    parameter int IDW   = $clog2(DEPTH)
);
    logic           i_node_vld;
    logic [14:0]    i_node_str;
    logic           i_newline;
    logic           o_stall;
    logic           o_edge_vld;
    logic [IDW-1:0] o_edge_src;
    logic [IDW-1:0] o_edge_dst;
    logic           i_edge_stall;
    logic [IDW:0]   o_num_nodes;
    logic           o_overflow;

    modport master (
        output i_node_vld, i_node_str, i_newline, i_edge_stall,
        input  o_stall, o_edge_vld, o_edge_src, o_edge_dst, o_num_nodes, o_overflow
    );

    modport slave (
        input  i_node_vld, i_node_str, i_newline, i_edge_stall,
        output o_stall, o_edge_vld, o_edge_src, o_edge_dst, o_num_nodes, o_overflow
    );
endinterface

// File: rtl/node_edge_sequencer.sv
// Turns "src: dst0 dst1 ..." token lines into directed edges, mapping each 15-bit
// node string to a dense ID through a sequentially searched allocation table.
module node_edge_sequencer #(
    parameter int DEPTH = 1024,
    parameter int IDW   = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  rst,
    node_edge_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;

    state_t         state, state_nxt;
    logic [14:0]    key_q, key_d;
    logic [IDW:0]   idx_q, idx_d;
    logic [IDW:0]   num_q, num_d;
    logic [IDW-1:0] src_q, src_d;
    logic [IDW-1:0] edge_src_q, edge_src_d;
    logic [IDW-1:0] edge_dst_q, edge_dst_d;
    logic           have_src_q, have_src_d;
    logic           line_drop_q, line_drop_d;
    logic           overflow_q, overflow_d;
    logic           edge_vld_q, edge_vld_d;

    logic [14:0]    table_mem [DEPTH];
    logic           tbl_we;
    logic           resolve;
    logic           table_full;

    // DEPTH is a power of two and the count never exceeds it, so the MSB alone means full.
    assign table_full = num_q[IDW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            key_q       <= '0;
            idx_q       <= '0;
            num_q       <= '0;
            src_q       <= '0;
            edge_src_q  <= '0;
            edge_dst_q  <= '0;
            have_src_q  <= 1'b0;
            line_drop_q <= 1'b0;
            overflow_q  <= 1'b0;
            edge_vld_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_q       <= key_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            src_q       <= src_d;
            edge_src_q  <= edge_src_d;
            edge_dst_q  <= edge_dst_d;
            have_src_q  <= have_src_d;
            line_drop_q <= line_drop_d;
            overflow_q  <= overflow_d;
            edge_vld_q  <= edge_vld_d;
        end
    end

    // Table contents are meaningless until allocated, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_mem[num_q[IDW-1:0]] <= key_q;
        end
    end

    always_comb begin
        state_nxt   = state;
        key_d       = key_q;
        idx_d       = idx_q;
        num_d       = num_q;
        src_d       = src_q;
        edge_src_d  = edge_src_q;
        edge_dst_d  = edge_dst_q;
        have_src_d  = have_src_q;
        line_drop_d = line_drop_q;
        overflow_d  = overflow_q;
        edge_vld_d  = edge_vld_q;
        tbl_we      = 1'b0;
        resolve     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_node_vld) begin
                    if (bus.i_newline) begin
                        have_src_d  = 1'b0;
                        line_drop_d = 1'b0;
                    end else if (!line_drop_q) begin
                        key_d     = bus.i_node_str;
                        idx_d     = '0;
                        state_nxt = SEARCH;
                    end
                end
            end

            SEARCH: begin
                // The count is frozen during a search, so reaching it means every entry missed.
                if (idx_q == num_q) begin
                    if (table_full) begin
                        overflow_d  = 1'b1;
                        line_drop_d = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        tbl_we  = 1'b1;
                        num_d   = num_q + 1'b1;
                        resolve = 1'b1;
                    end
                end else if (table_mem[idx_q[IDW-1:0]] == key_q) begin
                    resolve = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end

                if (resolve) begin
                    if (have_src_q) begin
                        edge_src_d = src_q;
                        edge_dst_d = idx_q[IDW-1:0];
                        edge_vld_d = 1'b1;
                        state_nxt  = EMIT;
                    end else begin
                        src_d      = idx_q[IDW-1:0];
                        have_src_d = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end

            EMIT: begin
                if (!bus.i_edge_stall) begin
                    edge_vld_d = 1'b0;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.o_stall     = (state != IDLE);
    assign bus.o_edge_vld  = edge_vld_q;
    assign bus.o_edge_src  = edge_src_q;
    assign bus.o_edge_dst  = edge_dst_q;
    assign bus.o_num_nodes = num_q;
    assign bus.o_overflow  = overflow_q;

endmodule

// File: tb/tb_node_edge_sequencer.sv
// Directed bench for node_edge_sequencer on a 4-entry table: line parsing, hit/miss
// latency, edge backpressure, table overflow and asynchronous reset mid-search.
module tb_node_edge_sequencer;

    localparam int DEPTH = 4;
    localparam int IDW   = $clog2(DEPTH);
    localparam int LIMIT = 200;

    logic clk;
    logic rst;
    int   checkCount;
    int   failCount;

    logic [IDW-1:0] edgeSrcQ[$];
    logic [IDW-1:0] edgeDstQ[$];

    node_edge_sequencer_if #(.DEPTH(DEPTH)) bus ();

    node_edge_sequencer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges transfer on the posedge after a negedge that shows valid without stall.
    always begin
        @(negedge clk);
        #1;
        if (rst && bus.o_edge_vld && !bus.i_edge_stall) begin
            edgeSrcQ.push_back(bus.o_edge_src);
            edgeDstQ.push_back(bus.o_edge_dst);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] str, input logic nl);
        int n;
        n = 0;
        while (bus.o_stall && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) checkOutput("acceptTimeout", 32'(n), 0);
        bus.i_node_vld = 1'b1;
        bus.i_node_str = str;
        bus.i_newline  = nl;
        @(negedge clk);
        bus.i_node_vld = 1'b0;
        bus.i_newline  = 1'b0;
        bus.i_node_str = '0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (bus.o_stall && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic sendToken(input string tag, input logic [14:0] str, input int expStall);
        int c;
        applyStimulus(str, 1'b0);
        waitIdle(c);
        checkOutput(tag, 32'(c), 32'(expStall));
    endtask

    task automatic sendNewline();
        int c;
        applyStimulus('0, 1'b1);
        waitIdle(c);
        checkOutput("newlineStall", 32'(c), 0);
    endtask

    task automatic checkEdge(input string tag, input logic [IDW-1:0] expSrc, input logic [IDW-1:0] expDst);
        logic [IDW-1:0] s;
        logic [IDW-1:0] d;
        checkOutput({tag, "_present"}, 32'(edgeSrcQ.size() != 0), 1);
        if (edgeSrcQ.size() != 0) begin
            s = edgeSrcQ.pop_front();
            d = edgeDstQ.pop_front();
            checkOutput({tag, "_src"}, 32'(s), 32'(expSrc));
            checkOutput({tag, "_dst"}, 32'(d), 32'(expDst));
        end
    endtask

    task automatic resetDut();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_node_vld   = 1'($urandom_range(0, 1));
            bus.i_node_str   = 15'($urandom);
            bus.i_newline    = 1'($urandom_range(0, 1));
            bus.i_edge_stall = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.i_node_vld   = 1'b0;
        bus.i_node_str   = '0;
        bus.i_newline    = 1'b0;
        bus.i_edge_stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        edgeSrcQ.delete();
        edgeDstQ.delete();
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b0;
        bus.i_node_vld   = 1'b0;
        bus.i_node_str   = '0;
        bus.i_newline    = 1'b0;
        bus.i_edge_stall = 1'b0;
        @(negedge clk);

        resetDut();
        checkOutput("rstStall",    32'(bus.o_stall), 0);
        checkOutput("rstEdgeVld",  32'(bus.o_edge_vld), 0);
        checkOutput("rstEdgeSrc",  32'(bus.o_edge_src), 0);
        checkOutput("rstEdgeDst",  32'(bus.o_edge_dst), 0);
        checkOutput("rstNumNodes", 32'(bus.o_num_nodes), 0);
        checkOutput("rstOverflow", 32'(bus.o_overflow), 0);

        // aaa=0, bbb=33, ccc=66: source costs k+1 search cycles, destinations add one EMIT cycle.
        sendToken("basicAaaStall", 15'd0, 1);
        sendToken("basicBbbStall", 15'd33, 3);
        sendToken("basicCccStall", 15'd66, 4);
        sendNewline();
        checkEdge("basicEdge0", 2'd0, 2'd1);
        checkEdge("basicEdge1", 2'd0, 2'd2);
        checkOutput("basicNumNodes", 32'(bus.o_num_nodes), 3);
        checkOutput("basicNoExtra", 32'(edgeSrcQ.size()), 0);

        sendToken("hitBbbStall", 15'd33, 2);
        sendToken("hitAaaStall", 15'd0, 2);
        sendNewline();
        checkEdge("hitEdge", 2'd1, 2'd0);
        checkOutput("hitNumNodes", 32'(bus.o_num_nodes), 3);
        checkOutput("hitNoExtra", 32'(edgeSrcQ.size()), 0);

        sendToken("bpCccStall", 15'd66, 3);
        bus.i_edge_stall = 1'b1;
        applyStimulus(15'd0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpHold", 32'({bus.o_edge_vld, bus.o_stall, bus.o_edge_src, bus.o_edge_dst}),
                        32'({1'b1, 1'b1, 2'd2, 2'd0}));
            @(negedge clk);
        end
        checkOutput("bpNoEarlyEdge", 32'(edgeSrcQ.size()), 0);
        bus.i_edge_stall = 1'b0;
        @(negedge clk);
        checkOutput("bpReleasedStall", 32'(bus.o_stall), 0);
        checkOutput("bpReleasedVld", 32'(bus.o_edge_vld), 0);
        checkEdge("bpEdge", 2'd2, 2'd0);
        sendNewline();
        checkOutput("bpNoExtra", 32'(edgeSrcQ.size()), 0);

        // ddd=99 is new, so the search would walk 4 cycles; reset lands in the middle.
        applyStimulus(15'd99, 1'b0);
        @(negedge clk);
        checkOutput("arstInSearch", 32'(bus.o_stall), 1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("arstStall", 32'(bus.o_stall), 0);
        checkOutput("arstNumNodes", 32'(bus.o_num_nodes), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sendToken("arstAaaStall", 15'd0, 1);
        checkOutput("arstAaaNum", 32'(bus.o_num_nodes), 1);
        sendToken("arstBbbStall", 15'd33, 3);
        sendNewline();
        checkEdge("arstEdge", 2'd0, 2'd1);

        resetDut();
        sendToken("ovfS0Stall", 15'd100, 1);
        sendToken("ovfS1Stall", 15'd200, 3);
        sendToken("ovfS2Stall", 15'd300, 4);
        sendToken("ovfS3Stall", 15'd400, 5);
        checkOutput("ovfNotYet", 32'(bus.o_overflow), 0);
        sendToken("ovfS4Stall", 15'd500, 5);
        checkOutput("ovfFlag", 32'(bus.o_overflow), 1);
        checkOutput("ovfNumNodes", 32'(bus.o_num_nodes), 4);
        sendToken("ovfDropStall", 15'd200, 0);
        sendNewline();
        checkEdge("ovfEdge0", 2'd0, 2'd1);
        checkEdge("ovfEdge1", 2'd0, 2'd2);
        checkEdge("ovfEdge2", 2'd0, 2'd3);
        checkOutput("ovfNoExtra", 32'(edgeSrcQ.size()), 0);

        sendToken("ovfNextSrcStall", 15'd300, 3);
        sendToken("ovfNextDstStall", 15'd100, 2);
        sendNewline();
        checkEdge("ovfNextEdge", 2'd2, 2'd0);
        checkOutput("ovfStickyFlag", 32'(bus.o_overflow), 1);
        checkOutput("ovfStickyNum", 32'(bus.o_num_nodes), 4);
        checkOutput("ovfFinalNoExtra", 32'(edgeSrcQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
